// File: rtl/dcm_phaseshift_multi.sv
// Shared PSEN/PSDONE sequencer stepping up to NUM_CH DCM variable phase shifters
// toward clamped signed targets, one step per channel visit in round-robin order.
module dcm_phaseshift_multi #(
    parameter int NUM_CH   = 2,
    parameter int PHASE_W  = 9,
    parameter int PS_LIMIT = 255,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NUM_CH-1:0]           load_i,
    input  logic [NUM_CH*PHASE_W-1:0]   value_i,
    input  logic [NUM_CH-1:0]           resync_i,
    output logic [NUM_CH*PHASE_W-1:0]   value_o,
    output logic [NUM_CH-1:0]           done_o,
    output logic [NUM_CH-1:0]           err_o,
    output logic                        busy_o,
    output logic [NUM_CH-1:0]           dcm_psen_o,
    output logic [NUM_CH-1:0]           dcm_psincdec_o,
    input  logic [NUM_CH-1:0]           dcm_psdone_i,
    input  logic [NUM_CH-1:0]           dcm_psovf_i
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_STEP,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PHASE_W-1:0]   r_target [NUM_CH];
    logic [PHASE_W-1:0]   r_actual [NUM_CH];
    logic [NUM_CH-1:0]    r_err;
    logic [CH_W-1:0]      r_ch;
    logic [CH_W-1:0]      r_ptr;
    logic                 r_dir;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_CH-1:0]    w_pending;
    logic                 w_found;
    logic [CH_W-1:0]      w_sel;
    logic                 w_sel_dir;
    logic                 w_inflight;
    logic                 w_take;
    logic                 w_timeout_hit;
    logic                 w_check_ok;
    logic [CH_W-1:0]      w_ptr_nxt;

    function automatic logic [PHASE_W-1:0] f_clamp(input logic [PHASE_W-1:0] v);
        logic signed [PHASE_W-1:0] sv;
        int                        s;
        sv = v;
        s  = 32'(sv);
        if (s > PS_LIMIT)
            s = PS_LIMIT;
        else if (s < -PS_LIMIT)
            s = -PS_LIMIT;
        return PHASE_W'(s);
    endfunction

    always_comb begin : p_pending
        w_pending = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            w_pending[k] = (r_actual[k] != r_target[k]) && !r_err[k];
    end

    always_comb begin : p_search
        int unsigned idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!w_found && w_pending[CH_W'(idx)]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(idx);
            end
        end
        w_sel_dir = $signed(r_target[w_sel]) > $signed(r_actual[w_sel]);
        w_ptr_nxt = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Resync on the serviced channel abandons the step; in SELECT any resync
    // holds one cycle so the direction is never latched from a stale phase.
    // The timeout count includes the PSEN cycle, so the error appears TIMEOUT
    // cycles after PSEN.
    always_comb begin : p_fsm
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_timeout_hit = 1'b0;
        w_check_ok    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_pending)
                    w_state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (!(|resync_i)) begin
                    if (w_found) begin
                        w_take      = 1'b1;
                        w_state_nxt = S_STEP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_STEP: begin
                w_state_nxt = resync_i[r_ch] ? S_SELECT : S_WAIT;
            end
            S_WAIT: begin
                if (resync_i[r_ch]) begin
                    w_state_nxt = S_SELECT;
                end else if (dcm_psdone_i[r_ch]) begin
                    w_state_nxt = S_CHECK;
                end else if (r_cnt == CNT_W'(TIMEOUT - 2)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_SELECT;
                end
            end
            S_CHECK: begin
                w_check_ok  = !resync_i[r_ch];
                w_state_nxt = S_SELECT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_target[k] <= '0;
                r_actual[k] <= '0;
            end
            r_err <= '0;
            r_ch  <= '0;
            r_ptr <= '0;
            r_dir <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_take) begin
                r_ch  <= w_sel;
                r_dir <= w_sel_dir;
            end
            if (r_state == S_STEP)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout_hit)
                r_err[r_ch] <= 1'b1;
            if (w_check_ok) begin
                if (dcm_psovf_i[r_ch])
                    r_err[r_ch] <= 1'b1;
                else
                    r_actual[r_ch] <= r_dir ? r_actual[r_ch] + 1'b1 : r_actual[r_ch] - 1'b1;
                r_ptr <= w_ptr_nxt;
            end
            // Later assignments win: resync zeroes the phase, load keeps its target.
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (resync_i[k]) begin
                    r_actual[k] <= '0;
                    r_err[k]    <= 1'b0;
                end
                if (load_i[k]) begin
                    r_target[k] <= f_clamp(value_i[k*PHASE_W +: PHASE_W]);
                    r_err[k]    <= 1'b0;
                end
            end
        end
    end

    always_comb begin : p_outputs
        w_inflight     = (r_state == S_STEP) || (r_state == S_WAIT) || (r_state == S_CHECK);
        busy_o         = (r_state != S_IDLE);
        dcm_psen_o     = '0;
        dcm_psincdec_o = '0;
        done_o         = '0;
        value_o        = '0;
        err_o          = r_err;
        if (r_state == S_STEP)
            dcm_psen_o[r_ch] = 1'b1;
        if (w_inflight)
            dcm_psincdec_o[r_ch] = r_dir;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            done_o[k] = !w_pending[k] && !(w_inflight && (r_ch == CH_W'(k)));
            value_o[k*PHASE_W +: PHASE_W] = r_actual[k];
        end
    end

endmodule
